// File: rtl/reg_file_wr_sched.sv
// Write-port scheduler for the 2R/1W register file: zero-sweeps registers 1..NUMREGS-1
// after reset or on request, then round-robin arbitrates writeback sources onto the port.
module reg_file_wr_sched #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int NUMREQ      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_start,
  input  logic [NUMREQ-1:0]             req_valid,
  input  logic [NUMREQ*LOG2NUMREGS-1:0] req_reg,
  input  logic [NUMREQ*WIDTH-1:0]       req_data,
  output logic [NUMREQ-1:0]             req_ready,
  output logic [LOG2NUMREGS-1:0]        c_reg,
  output logic [WIDTH-1:0]              c_writedatain,
  output logic                          c_we,
  output logic                          init_done
);

  localparam int RRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_next;
  logic [LOG2NUMREGS-1:0]  counter;
  logic [RRW-1:0]          rr;
  logic                    grant_any;
  logic [RRW-1:0]          grant_idx;
  logic                    sweep_last;
  int unsigned             idx;

  // The sweep ends one cycle after the top register's write is presented, so the
  // write port is never shared between the sweep and a granted requester.
  assign sweep_last = c_we && (c_reg == LOG2NUMREGS'(NUMREGS - 1));
  assign init_done  = (state == RUN);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    idx        = 0;
    case (state)
      INIT: begin
        if (sweep_last) state_next = RUN;
      end
      RUN: begin
        if (init_start) begin
          state_next = INIT;
        end else begin
          for (int unsigned k = 0; k < NUMREQ; k++) begin
            idx = (int'(rr) + k) % NUMREQ;
            if (!grant_any && req_valid[idx]) begin
              grant_any = 1'b1;
              grant_idx = RRW'(idx);
            end
          end
        end
        if (grant_any) req_ready[grant_idx] = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      counter       <= LOG2NUMREGS'(1);
      rr            <= '0;
      c_we          <= 1'b0;
      c_reg         <= '0;
      c_writedatain <= '0;
    end else begin
      state <= state_next;
      case (state)
        INIT: begin
          if (sweep_last) begin
            c_we <= 1'b0;
          end else begin
            c_reg         <= counter;
            c_writedatain <= '0;
            c_we          <= 1'b1;
            counter       <= counter + LOG2NUMREGS'(1);
          end
        end
        RUN: begin
          if (init_start) counter <= LOG2NUMREGS'(1);
          c_we <= grant_any;
          if (grant_any) begin
            c_reg         <= req_reg[int'(grant_idx)*LOG2NUMREGS +: LOG2NUMREGS];
            c_writedatain <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
            rr            <= (grant_idx == RRW'(NUMREQ - 1)) ? '0 : grant_idx + RRW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_sched.sv
// Self-checking bench for reg_file_wr_sched: directed scenarios plus random traffic,
// checked cycle by cycle against a cycle-count/queue-free behavioural model.
module tb_reg_file_wr_sched;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int L  = 5;
  localparam int NQ = 3;

  logic            clk = 1'b0;
  logic            reset, init_start;
  logic [NQ-1:0]   req_valid, req_ready;
  logic [NQ*L-1:0] req_reg;
  logic [NQ*W-1:0] req_data;
  logic [L-1:0]    c_reg;
  logic [W-1:0]    c_writedatain;
  logic            c_we, init_done;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int            m_run, m_cyc, m_rr;
  logic          m_we, m_done;
  logic [L-1:0]  m_reg;
  logic [W-1:0]  m_data;
  logic [NQ-1:0] m_ready;
  logic [NQ-1:0] obs_ready;
  logic          obs_done;
  int            m_grant;

  logic [W-1:0] rf [NR];

  reg_file_wr_sched #(.WIDTH(W), .NUMREGS(NR), .LOG2NUMREGS(L), .NUMREQ(NQ)) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .c_reg(c_reg), .c_writedatain(c_writedatain),
    .c_we(c_we), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (c_we) rf[c_reg] <= c_writedatain;

  // One clock: drive inputs, predict combinational ready, clock, predict registered outputs.
  task automatic cycle(input logic rst, input logic ist, input logic [NQ-1:0] v,
                       input logic [NQ*L-1:0] r, input logic [NQ*W-1:0] d);
    int g;
    reset = rst; init_start = ist; req_valid = v; req_reg = r; req_data = d;
    #1;
    g = -1;
    m_ready = '0;
    if (m_run != 0 && !ist)
      for (int k = 0; k < NQ; k++)
        if (g < 0 && v[(m_rr + k) % NQ]) g = (m_rr + k) % NQ;
    if (g >= 0) m_ready[g] = 1'b1;
    m_grant   = g;
    m_done    = (m_run != 0);
    obs_ready = req_ready;
    obs_done  = init_done;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_cyc = 0; m_rr = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
    end else if (m_run == 0) begin
      m_cyc++;
      if (m_cyc < NR) begin
        m_we = 1'b1; m_reg = L'(m_cyc); m_data = '0;
      end else begin
        m_run = 1; m_we = 1'b0;
      end
    end else if (ist) begin
      m_run = 0; m_cyc = 0; m_we = 1'b0;
    end else if (g >= 0) begin
      m_we = 1'b1; m_reg = r[g*L +: L]; m_data = d[g*W +: W]; m_rr = (g + 1) % NQ;
    end else begin
      m_we = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int we_count = 0;
    for (int i = 0; i < NR; i++) rf[i] = 32'hA5A5_A5A5;
    cycle(1'b1, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, '0);
    n_cmp++;
    if ({c_we, c_reg, c_writedatain, init_done} !== '0) begin
      n_bad++; $display("FAIL reset_state: got we=%b reg=%0d data=%h done=%b, want all 0", c_we, c_reg, c_writedatain, init_done);
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, '0, '0, '0);
      if (c_we) we_count++;
      n_cmp += 3;
      if (obs_ready !== m_ready || obs_done !== m_done) begin
        n_bad++; $display("FAIL reset_sweep_ready cyc%0d: ready=%b done=%b, want %b %b", i, obs_ready, obs_done, m_ready, m_done);
      end
      if (c_we !== m_we || c_reg !== m_reg) begin
        n_bad++; $display("FAIL reset_sweep_port cyc%0d: we=%b reg=%0d, want %b %0d", i, c_we, c_reg, m_we, m_reg);
      end
      if (c_writedatain !== m_data) begin
        n_bad++; $display("FAIL reset_sweep_data cyc%0d: %h, want %h", i, c_writedatain, m_data);
      end
    end
    n_cmp += 2;
    if (we_count != NR - 1) begin
      n_bad++; $display("FAIL sweep_len: c_we high %0d cycles, want %0d", we_count, NR - 1);
    end
    if (rf[5] !== '0) begin
      n_bad++; $display("FAIL r5_zero: %h, want 0", rf[5]);
    end
  endtask

  // Scenario runner: fixed inputs for n cycles, drops a requester's valid once it is granted.
  task automatic run_fixed(input string name, input int n, input logic ist_first,
                           input logic [NQ-1:0] v_in, input logic hold_all,
                           input logic [NQ*L-1:0] r, input logic [NQ*W-1:0] d);
    logic [NQ-1:0] v = v_in;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, (i == 0) ? ist_first : 1'b0, v, r, d);
      if (!hold_all) v = v & ~m_ready;
      n_cmp += 3;
      if (obs_ready !== m_ready || obs_done !== m_done) begin
        n_bad++; $display("FAIL %s_ready cyc%0d: ready=%b done=%b, want %b %b", name, i, obs_ready, obs_done, m_ready, m_done);
      end
      if (c_we !== m_we || c_reg !== m_reg) begin
        n_bad++; $display("FAIL %s_port cyc%0d: we=%b reg=%0d, want %b %0d", name, i, c_we, c_reg, m_we, m_reg);
      end
      if (c_writedatain !== m_data) begin
        n_bad++; $display("FAIL %s_data cyc%0d: %h, want %h", name, i, c_writedatain, m_data);
      end
    end
  endtask

  task automatic test_round_robin();
    run_fixed("rr_all", 9, 1'b0, 3'b111, 1'b1, {5'd3, 5'd2, 5'd1},
              {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    n_cmp++;
    if (c_reg !== 5'd3 || c_writedatain !== 32'hCCCC_CCCC) begin
      n_bad++; $display("FAIL rr_last: reg=%0d data=%h, want 3 cccccccc", c_reg, c_writedatain);
    end
  endtask

  task automatic test_back_to_back();
    run_fixed("rr_set", 1, 1'b0, 3'b001, 1'b0, {5'd9, 5'd8, 5'd4}, {32'h3, 32'h2, 32'h1});
    run_fixed("rr_101", 3, 1'b0, 3'b101, 1'b0, {5'd12, 5'd11, 5'd10}, {32'h33, 32'h22, 32'h11});
    run_fixed("single1", 2, 1'b0, 3'b010, 1'b0, {5'd0, 5'd17, 5'd0}, {32'h0, 32'h1717, 32'h0});
    run_fixed("reg0", 2, 1'b0, 3'b100, 1'b0, {5'd0, 5'd0, 5'd0}, {32'h5A, 32'h0, 32'h0});
  endtask

  task automatic test_req_during_init();
    cycle(1'b1, 1'b0, '0, '0, '0);
    run_fixed("init_req", 36, 1'b0, 3'b001, 1'b0, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hDEAD_BEEF});
  endtask

  task automatic test_init_start();
    run_fixed("init_start", 36, 1'b1, 3'b010, 1'b0, {5'd0, 5'd21, 5'd0}, {32'h0, 32'h2121, 32'h0});
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, '0, '0, '0);
    run_fixed("pre_mid", 10, 1'b0, 3'b000, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 3'b011, '0, '0);
    n_cmp++;
    if (c_we !== 1'b0 || init_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: we=%b done=%b, want 0 0", c_we, init_done);
    end
    run_fixed("post_mid", 34, 1'b0, 3'b000, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic [NQ-1:0]   v;
    logic [NQ*L-1:0] r;
    logic [NQ*W-1:0] d;
    logic ist, rst;
    for (int i = 0; i < 400; i++) begin
      v   = NQ'($urandom_range(0, 7));
      r   = (NQ*L)'($urandom);
      d   = {$urandom, $urandom, $urandom};
      ist = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle(rst, ist, v, r, d);
      n_cmp += 3;
      if (obs_ready !== m_ready || obs_done !== m_done) begin
        n_bad++; $display("FAIL rand_ready cyc%0d: ready=%b done=%b, want %b %b", i, obs_ready, obs_done, m_ready, m_done);
      end
      if (c_we !== m_we || c_reg !== m_reg) begin
        n_bad++; $display("FAIL rand_port cyc%0d: we=%b reg=%0d, want %b %0d", i, c_we, c_reg, m_we, m_reg);
      end
      if (c_writedatain !== m_data) begin
        n_bad++; $display("FAIL rand_data cyc%0d: %h, want %h", i, c_writedatain, m_data);
      end
    end
  endtask

  initial begin
    reset = 1'b1; init_start = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    m_run = 0; m_cyc = 0; m_rr = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
    m_ready = '0; m_done = 1'b0; m_grant = -1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_req_during_init();
    test_init_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
